// File: rtl/axis_axi_writer_pkg.sv
// Shared types and AXI constants for the stream-to-AXI write path.
package axis_axi_writer_pkg;

   typedef enum logic [1:0] {
      ST_FILL = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2,
      ST_B    = 2'd3
   } state_t;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [2:0] SIZE_4B    = 3'b010;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axis_word_packer.sv
// Packs a little-endian byte stream into 32-bit words with byte strobes.
// A word is presented for commit on its 4th byte or on a byte flagged last;
// lanes not yet written stay zero with their strobes clear.
module axis_word_packer
   import axis_axi_writer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        byte_en,
   input  logic [7:0]  byte_data,
   input  logic        byte_last,
   output logic        word_commit,
   output logic [31:0] word_data,
   output logic [3:0]  word_strb,
   output logic        word_last
);

   logic [1:0]  lane;
   logic [31:0] part_data;
   logic [3:0]  part_strb;

   assign word_commit = byte_en && ((lane == 2'd3) || byte_last);
   assign word_last   = byte_last;

   // Merge the incoming byte into the partial word at the current lane.
   always_comb begin
      word_data = part_data;
      word_strb = part_strb;
      word_data[{lane, 3'b000} +: 8] = byte_data;
      word_strb[lane] = 1'b1;
   end

   // Track lane position and hold the partial word until it commits.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lane      <= '0;
         part_data <= '0;
         part_strb <= '0;
      end else if (word_commit) begin
         lane      <= '0;
         part_data <= '0;
         part_strb <= '0;
      end else if (byte_en) begin
         lane      <= lane + 2'd1;
         part_data <= word_data;
         part_strb <= word_strb;
      end
   end

endmodule

// File: rtl/axis_axi_writer.sv
// AXI-Stream byte sink that buffers packed words and writes them to memory
// as INCR bursts over AW/W/B. Bursts are cut at MAX_BURST*4-byte boundaries.
module axis_axi_writer
   import axis_axi_writer_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8,
   parameter int MAX_BURST  = 16,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            s_tdata,
   input  logic                  s_tvalid,
   output logic                  s_tready,
   input  logic                  s_tlast,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic                  done,
   output logic                  err
);

   localparam int LOG2_MB = $clog2(MAX_BURST);
   localparam int CNT_W   = LOG2_MB + 1;

   state_t                  state, state_nxt;
   logic                    active;
   logic [CNT_W-1:0]        count;
   logic [LOG2_MB-1:0]      beat;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic                    tlast_pending;
   logic                    done_q;
   logic                    err_q;

   logic [DATA_WIDTH-1:0]   buf_data [MAX_BURST];
   logic [STRB_WIDTH-1:0]   buf_strb [MAX_BURST];

   logic                    accept;
   logic                    word_commit;
   logic [31:0]             word_data;
   logic [3:0]              word_strb;
   logic                    word_last;

   logic [LOG2_MB-1:0]      word_off;
   logic [CNT_W-1:0]        burst_limit;
   logic [CNT_W-1:0]        count_inc;
   logic                    buf_full;
   logic                    beat_last;
   logic                    w_hs;
   logic                    b_hs;
   logic                    unused_bid;

   assign unused_bid  = ^m_axi_bid;

   assign word_off    = wr_addr[2 +: LOG2_MB];
   assign burst_limit = CNT_W'(MAX_BURST) - CNT_W'(word_off);
   assign count_inc   = count + CNT_W'(1);
   assign buf_full    = (count == CNT_W'(MAX_BURST));
   assign beat_last   = (CNT_W'(beat) == (count - CNT_W'(1)));

   // active holds ready low through reset and the first cycle after release
   assign s_tready    = active && (state == ST_FILL) && !buf_full;
   assign accept      = s_tvalid && s_tready;
   assign w_hs        = m_axi_wvalid && m_axi_wready;
   assign b_hs        = m_axi_bready && m_axi_bvalid;

   assign m_axi_awid    = '0;
   assign m_axi_awaddr  = wr_addr;
   assign m_axi_awlen   = 8'(count) - 8'd1;
   assign m_axi_awsize  = SIZE_4B;
   assign m_axi_awburst = BURST_INCR;
   assign m_axi_wdata   = buf_data[beat];
   assign m_axi_wstrb   = buf_strb[beat];
   assign m_axi_wlast   = (state == ST_W) && beat_last;
   assign done          = done_q;
   assign err           = err_q;

   axis_word_packer u_packer (
      .clk         (clk),
      .rst_n       (rst_n),
      .byte_en     (accept),
      .byte_data   (s_tdata),
      .byte_last   (s_tlast),
      .word_commit (word_commit),
      .word_data   (word_data),
      .word_strb   (word_strb),
      .word_last   (word_last)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_FILL;
      else        state <= state_nxt;
   end

   // Next-state decode and channel valid/ready outputs.
   always_comb begin
      state_nxt     = state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      case (state)
         ST_FILL: begin
            if (word_commit && ((count_inc == burst_limit) || word_last))
               state_nxt = ST_AW;
         end
         ST_AW: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) state_nxt = ST_W;
         end
         ST_W: begin
            m_axi_wvalid = 1'b1;
            if (m_axi_wready && beat_last) state_nxt = ST_B;
         end
         ST_B: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_nxt = ST_FILL;
         end
         default: state_nxt = ST_FILL;
      endcase
   end

   // Burst buffer storage; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (word_commit) begin
         buf_data[count[LOG2_MB-1:0]] <= word_data;
         buf_strb[count[LOG2_MB-1:0]] <= word_strb;
      end
   end

   // Word count, beat index, address advance and completion status.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         active        <= 1'b0;
         count         <= '0;
         beat          <= '0;
         wr_addr       <= BASE_ADDR;
         tlast_pending <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         active <= 1'b1;
         done_q <= 1'b0;
         if (word_commit) begin
            count <= count_inc;
            if (word_last) tlast_pending <= 1'b1;
         end
         if (w_hs) beat <= beat + LOG2_MB'(1);
         if (b_hs) begin
            err_q         <= err_q | (m_axi_bresp != RESP_OKAY);
            wr_addr       <= wr_addr + (ADDR_WIDTH'(count) << 2);
            count         <= '0;
            beat          <= '0;
            done_q        <= tlast_pending;
            tlast_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axis_axi_writer.sv
`timescale 1ns/1ps
// Self-checking bench for axis_axi_writer: two instances (base 0x0000 and
// 0x0038) share stimulus, only the selected one is enabled and observed.
module tb_axis_axi_writer;

   localparam int MB = 16;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       sel;
   logic [7:0] s_tdata;
   logic       s_tvalid, s_tlast;
   logic       awready, wready, bvalid;
   logic [1:0] bresp;

   logic        tready  [2];
   logic [7:0]  awid    [2];
   logic [15:0] awaddr  [2];
   logic [7:0]  awlen   [2];
   logic [2:0]  awsize  [2];
   logic [1:0]  awburst [2];
   logic        awvalid [2];
   logic [31:0] wdata   [2];
   logic [3:0]  wstrb   [2];
   logic        wlast   [2];
   logic        wvalid  [2];
   logic        bready  [2];
   logic        done    [2];
   logic        err     [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic en;
      assign en = (sel == 1'(g));
      axis_axi_writer #(.BASE_ADDR((g == 0) ? 16'h0000 : 16'h0038)) dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .s_tdata       (s_tdata),
         .s_tvalid      (s_tvalid && en),
         .s_tready      (tready[g]),
         .s_tlast       (s_tlast),
         .m_axi_awid    (awid[g]),
         .m_axi_awaddr  (awaddr[g]),
         .m_axi_awlen   (awlen[g]),
         .m_axi_awsize  (awsize[g]),
         .m_axi_awburst (awburst[g]),
         .m_axi_awvalid (awvalid[g]),
         .m_axi_awready (awready && en),
         .m_axi_wdata   (wdata[g]),
         .m_axi_wstrb   (wstrb[g]),
         .m_axi_wlast   (wlast[g]),
         .m_axi_wvalid  (wvalid[g]),
         .m_axi_wready  (wready && en),
         .m_axi_bid     (8'h00),
         .m_axi_bresp   (bresp),
         .m_axi_bvalid  (bvalid && en),
         .m_axi_bready  (bready[g]),
         .done          (done[g]),
         .err           (err[g])
      );
   end

   logic        cur_tready, cur_awvalid, cur_wvalid, cur_wlast, cur_bready, cur_done, cur_err;
   logic [7:0]  cur_awid, cur_awlen;
   logic [15:0] cur_awaddr;
   logic [2:0]  cur_awsize;
   logic [1:0]  cur_awburst;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_wstrb;
   logic        cur_awready, cur_wready;

   assign cur_tready  = tready[sel];
   assign cur_awid    = awid[sel];
   assign cur_awaddr  = awaddr[sel];
   assign cur_awlen   = awlen[sel];
   assign cur_awsize  = awsize[sel];
   assign cur_awburst = awburst[sel];
   assign cur_awvalid = awvalid[sel];
   assign cur_wdata   = wdata[sel];
   assign cur_wstrb   = wstrb[sel];
   assign cur_wlast   = wlast[sel];
   assign cur_wvalid  = wvalid[sel];
   assign cur_bready  = bready[sel];
   assign cur_done    = done[sel];
   assign cur_err     = err[sel];
   assign cur_awready = awready;
   assign cur_wready  = wready;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct { logic [15:0] addr; logic [7:0] len; } aw_t;
   typedef struct { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
   aw_t aw_q[$];
   w_t  w_q[$];
   logic [15:0] model_addr [2];

   task automatic push_model(input int unsigned n, input logic [7:0] seed, input logic [7:0] step);
      int unsigned nwords, w, limit, cnt, idx;
      logic [15:0] a;
      aw_t ea;
      w_t  ew;
      nwords = (n + 3) / 4;
      a = model_addr[sel];
      w = 0;
      while (w < nwords) begin
         limit = MB - ((int'(a) >> 2) % MB);
         cnt = (nwords - w < limit) ? nwords - w : limit;
         ea.addr = a;
         ea.len  = 8'(cnt - 1);
         aw_q.push_back(ea);
         for (int unsigned b = 0; b < cnt; b++) begin
            ew.data = '0;
            ew.strb = '0;
            for (int unsigned k = 0; k < 4; k++) begin
               idx = 4 * (w + b) + k;
               if (idx < n) begin
                  ew.data[8*k +: 8] = 8'(int'(seed) + int'(step) * idx);
                  ew.strb[k] = 1'b1;
               end
            end
            ew.last = (b == cnt - 1);
            w_q.push_back(ew);
         end
         a = a + 16'(4 * cnt);
         w = w + cnt;
      end
      model_addr[sel] = a;
   endtask

   // ---------------- slave responder ----------------
   int unsigned aw_delay = 0;
   int unsigned aw_wait  = 0;
   bit          w_toggle = 1'b0;
   bit          w_block  = 1'b0;
   logic [1:0]  bresp_cfg = 2'b00;

   initial begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
      forever begin
         @(posedge clk); #1;
         if (cur_awvalid) begin
            awready = (aw_wait >= aw_delay);
            aw_wait++;
         end else begin
            awready = 1'b0;
            aw_wait = 0;
         end
         if (w_block)       wready = 1'b0;
         else if (w_toggle) wready = ~wready;
         else               wready = 1'b1;
         bvalid = cur_bready;
         bresp  = cur_bready ? bresp_cfg : 2'b00;
      end
   end

   // ---------------- monitor (samples mid-cycle) ----------------
   int unsigned done_cnt = 0, aw_seen = 0, w_seen = 0, aw_open = 0;
   logic [15:0] cap_awaddr;
   logic [7:0]  cap_awlen;
   logic [31:0] cap_wdata;
   logic [3:0]  cap_wstrb;
   bit          aw_pend = 1'b0, w_pend = 1'b0;
   logic [23:0] aw_prev;
   logic [36:0] w_prev;
   aw_t         m_ea;
   w_t          m_ew;

   always @(negedge clk) begin
      if (!rst_n) begin
         aw_pend = 1'b0;
         w_pend  = 1'b0;
         aw_open = 0;
      end else begin
         if (aw_pend)
            check("aw_stable", {cur_awvalid, cur_awaddr, cur_awlen}, {1'b1, aw_prev});
         if (w_pend)
            check("w_stable", {cur_wvalid, cur_wdata, cur_wstrb, cur_wlast}, {1'b1, w_prev});
         if (cur_awvalid || cur_wvalid || cur_bready)
            check("tready_busy", cur_tready, 1'b0);
         if (cur_awvalid && cur_awready) begin
            if (aw_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL aw_unexpected: AW addr 0x%0h len %0d, expected no AW", cur_awaddr, cur_awlen);
            end else begin
               m_ea = aw_q.pop_front();
               check("awaddr", cur_awaddr, m_ea.addr);
               check("awlen", cur_awlen, m_ea.len);
            end
            check("aw_consts", {cur_awid, cur_awsize, cur_awburst}, {8'h00, 3'b010, 2'b01});
            if (aw_seen == 0) begin cap_awaddr = cur_awaddr; cap_awlen = cur_awlen; end
            aw_seen++;
            aw_open++;
         end
         if (cur_wvalid && cur_wready) begin
            check("w_after_aw", aw_open != 0, 1'b1);
            if (w_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL w_unexpected: W data 0x%0h, expected no W beat", cur_wdata);
            end else begin
               m_ew = w_q.pop_front();
               check("wdata", cur_wdata, m_ew.data);
               check("wstrb", cur_wstrb, m_ew.strb);
               check("wlast", cur_wlast, m_ew.last);
            end
            if (w_seen == 0) begin cap_wdata = cur_wdata; cap_wstrb = cur_wstrb; end
            w_seen++;
            if (cur_wlast && aw_open != 0) aw_open--;
         end
         if (cur_done) done_cnt++;
         aw_pend = cur_awvalid && !cur_awready;
         aw_prev = {cur_awaddr, cur_awlen};
         w_pend  = cur_wvalid && !cur_wready;
         w_prev  = {cur_wdata, cur_wstrb, cur_wlast};
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic send_bytes(input int unsigned n, input logic [7:0] seed, input logic [7:0] step);
      bit got;
      push_model(n, seed, step);
      for (int unsigned i = 0; i < n; i++) begin
         s_tvalid = 1'b1;
         s_tdata  = 8'(int'(seed) + int'(step) * i);
         s_tlast  = (i == n - 1);
         got = 1'b0;
         for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            got = cur_tready;
            @(posedge clk); #1;
         end
         if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL byte_timeout: byte %0d tready stayed 0, expected 1", i);
            s_tvalid = 1'b0; s_tlast = 1'b0;
            return;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      check("aw_latency", cur_awvalid, 1'b1);
   endtask

   task automatic run_pkt(input string tag, input int unsigned n, input logic [7:0] seed,
                          input logic [7:0] step, input int unsigned exp_bursts,
                          input logic [15:0] exp_aw0, input logic [7:0] exp_len0,
                          input logic [31:0] exp_wd0, input logic [3:0] exp_ws0);
      int unsigned d0;
      bit got;
      d0 = done_cnt;
      aw_seen = 0;
      w_seen  = 0;
      send_bytes(n, seed, step);
      got = 1'b0;
      for (int c = 0; c < 3000 && !got; c++) begin
         @(negedge clk);
         got = (done_cnt != d0);
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL %s_done_timeout: done count %0d, expected %0d", tag, done_cnt - d0, 1);
      end
      repeat (4) @(negedge clk);
      check({tag, "_done_once"}, done_cnt - d0, 1);
      check({tag, "_bursts"}, aw_seen, exp_bursts);
      check({tag, "_awaddr0"}, cap_awaddr, exp_aw0);
      check({tag, "_awlen0"}, cap_awlen, exp_len0);
      check({tag, "_wdata0"}, cap_wdata, exp_wd0);
      check({tag, "_wstrb0"}, cap_wstrb, exp_ws0);
      check({tag, "_aw_left"}, aw_q.size(), 0);
      check({tag, "_w_left"}, w_q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_state", {cur_awvalid, cur_wvalid, cur_bready, cur_tready, cur_done, cur_err}, 6'b0);
      aw_q.delete();
      w_q.delete();
      model_addr[0] = 16'h0000;
      model_addr[1] = 16'h0038;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      bit          rst;
      bit          sel;
      int unsigned n;
      logic [7:0]  seed;
      logic [7:0]  step;
      int unsigned bursts;
      logic [15:0] aw0;
      logic [7:0]  len0;
      logic [31:0] wd0;
      logic [3:0]  ws0;
   } vec_t;

   vec_t vecs [7];

   initial begin
      vecs[0] = '{1'b1, 1'b0,  4, 8'h11, 8'h11, 1, 16'h0000, 8'd0,  32'h44332211, 4'hF};
      vecs[1] = '{1'b1, 1'b0,  6, 8'h01, 8'h01, 1, 16'h0000, 8'd1,  32'h04030201, 4'hF};
      vecs[2] = '{1'b0, 1'b0,  4, 8'hA0, 8'h01, 1, 16'h0008, 8'd0,  32'hA3A2A1A0, 4'hF};
      vecs[3] = '{1'b1, 1'b0, 80, 8'h40, 8'h03, 2, 16'h0000, 8'd15, 32'h49464340, 4'hF};
      vecs[4] = '{1'b0, 1'b0,  3, 8'h10, 8'h01, 1, 16'h0050, 8'd0,  32'h00121110, 4'h7};
      vecs[5] = '{1'b0, 1'b0, 65, 8'h00, 8'h01, 2, 16'h0054, 8'd10, 32'h03020100, 4'hF};
      vecs[6] = '{1'b1, 1'b1, 24, 8'h05, 8'h07, 2, 16'h0038, 8'd1,  32'h1A130C05, 4'hF};

      sel = 1'b0;
      rst_n = 1'b0;
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tdata  = 8'h00;
      model_addr[0] = 16'h0000;
      model_addr[1] = 16'h0038;
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         sel = vecs[i].sel;
         if (vecs[i].rst) do_reset();
         run_pkt($sformatf("vec%0d", i), vecs[i].n, vecs[i].seed, vecs[i].step, vecs[i].bursts,
                 vecs[i].aw0, vecs[i].len0, vecs[i].wd0, vecs[i].ws0);
      end

      // Slow AW, toggling wready and an error response; err must stick.
      sel = 1'b0;
      check("err_clear", cur_err, 1'b0);
      aw_delay  = 5;
      w_toggle  = 1'b1;
      bresp_cfg = 2'b10;
      run_pkt("bp", 12, 8'h30, 8'h05, 1, 16'h0000, 8'd2, 32'h3F3A3530, 4'hF);
      check("err_set", cur_err, 1'b1);
      aw_delay  = 0;
      w_toggle  = 1'b0;
      bresp_cfg = 2'b00;
      run_pkt("sticky", 4, 8'h77, 8'h01, 1, 16'h000C, 8'd0, 32'h7A797877, 4'hF);
      check("err_sticky", cur_err, 1'b1);

      // Reset while stalled in the W phase abandons the burst.
      begin
         bit got;
         w_block = 1'b1;
         send_bytes(8, 8'h90, 8'h01);
         got = 1'b0;
         for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            got = cur_wvalid;
         end
         if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL wvalid_timeout: wvalid stayed 0, expected 1");
         end
         @(posedge clk); #1;
         rst_n = 1'b0;
         @(posedge clk);
         @(negedge clk);
         check("reset_mid_w", {cur_awvalid, cur_wvalid, cur_bready, cur_tready, cur_done, cur_err}, 6'b0);
         aw_q.delete();
         w_q.delete();
         model_addr[0] = 16'h0000;
         model_addr[1] = 16'h0038;
         @(posedge clk); #1;
         w_block = 1'b0;
         rst_n = 1'b1;
         run_pkt("post_rst", 4, 8'hC1, 8'h11, 1, 16'h0000, 8'd0, 32'hF4E3D2C1, 4'hF);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected test to complete");
      $fatal(1, "watchdog");
   end

endmodule
